reaction_ctrl: RTL and testbench



---
 rtl/reaction_pkg.sv | 31 +++
 rtl/lfsr16.sv | 24 ++
 rtl/reaction_ctrl.sv | 120 ++++++++++++
 tb/tb_reaction_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/reaction_pkg.sv
// Shared constants for the reaction-timer trial controller: widths, state codes,
// LFSR taps and default timing.
package reaction_pkg;

    localparam int CNT_W = 14;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WAIT  = 3'd1;
    localparam logic [2:0] ST_ARM   = 3'd2;
    localparam logic [2:0] ST_GO    = 3'd3;
    localparam logic [2:0] ST_SHOW  = 3'd4;
    localparam logic [2:0] ST_EARLY = 3'd5;
    localparam logic [2:0] ST_TOUT  = 3'd6;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int          DEF_MIN_DELAY = 1000;
    localparam int          DEF_RAND_BITS = 11;
    localparam int          DEF_MAX_REACT = 9999;
    localparam logic [15:0] DEF_LFSR_SEED = 16'hACE1;

    // Foreperiod = min_d + low rand_bits of the LFSR
    function automatic logic [CNT_W-1:0] trial_delay(input int min_d, input int rand_bits,
                                                     input logic [15:0] q);
        logic [15:0] mask;
        mask = (16'd1 << rand_bits) - 16'd1;
        return CNT_W'(min_d) + CNT_W'(q & mask);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR used to randomise the trial foreperiod.
module lfsr16
    import reaction_pkg::*;
#(
    parameter logic [15:0] SEED = DEF_LFSR_SEED
) (
    input  logic        clk,
    input  logic        areset_n,
    output logic [15:0] q
);

    logic fb;

    assign fb = ^(q & LFSR_TAPS);

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            q <= SEED;
        end else begin
            q <= {q[14:0], fb};
        end
    end

endmodule

// File: rtl/reaction_ctrl.sv
// Reaction-timer trial sequencer: random foreperiod, GO LED, reaction capture.
//   state | meaning
//   IDLE  | after reset, waiting for first start press
//   WAIT  | foreperiod running on the counter
//   ARM   | one cycle with the counter cleared before timing the reaction
//   GO    | LED lit, counting reaction time
//   SHOW  | valid reaction time held
//   EARLY | react pressed during the foreperiod
//   TOUT  | no reaction within MAX_REACT
module reaction_ctrl
    import reaction_pkg::*;
#(
    parameter int          MIN_DELAY = DEF_MIN_DELAY,
    parameter int          RAND_BITS = DEF_RAND_BITS,
    parameter int          MAX_REACT = DEF_MAX_REACT,
    parameter logic [15:0] LFSR_SEED = DEF_LFSR_SEED
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic             start_btn,
    input  logic             react_btn,
    input  logic             cnt_done,
    input  logic [CNT_W-1:0] cnt_value,
    output logic             cnt_enable,
    output logic [CNT_W-1:0] cnt_limit,
    output logic             led_go,
    output logic [CNT_W-1:0] result,
    output logic             result_valid,
    output logic             too_early,
    output logic             timeout
);

    logic [2:0]       state;
    logic             start_q;
    logic             react_q;
    logic             start_rise;
    logic             react_rise;
    logic [15:0]      lfsr_q;
    logic [CNT_W-1:0] delay;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk      (clk),
        .areset_n (areset_n),
        .q        (lfsr_q)
    );

    assign start_rise = start_btn & ~start_q;
    assign react_rise = react_btn & ~react_q;
    assign delay      = trial_delay(MIN_DELAY, RAND_BITS, lfsr_q);

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state        <= ST_IDLE;
            start_q      <= 1'b0;
            react_q      <= 1'b0;
            cnt_enable   <= 1'b0;
            cnt_limit    <= '0;
            led_go       <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            too_early    <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            start_q <= start_btn;
            react_q <= react_btn;
            case (state)
                // Terminal states share the IDLE exit: a start edge launches a fresh trial
                ST_IDLE, ST_SHOW, ST_EARLY, ST_TOUT: begin
                    if (start_rise) begin
                        state        <= ST_WAIT;
                        cnt_enable   <= 1'b1;
                        cnt_limit    <= delay;
                        result       <= '0;
                        result_valid <= 1'b0;
                        too_early    <= 1'b0;
                        timeout      <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (react_rise) begin
                        state      <= ST_EARLY;
                        cnt_enable <= 1'b0;
                        too_early  <= 1'b1;
                        result     <= '0;
                    end else if (cnt_done) begin
                        state      <= ST_ARM;
                        cnt_enable <= 1'b0;
                        cnt_limit  <= CNT_W'(MAX_REACT);
                    end
                end
                ST_ARM: begin
                    state      <= ST_GO;
                    cnt_enable <= 1'b1;
                    led_go     <= 1'b1;
                end
                ST_GO: begin
                    if (react_rise) begin
                        state        <= ST_SHOW;
                        result       <= cnt_value;
                        result_valid <= 1'b1;
                        led_go       <= 1'b0;
                        cnt_enable   <= 1'b0;
                    end else if (cnt_done) begin
                        state      <= ST_TOUT;
                        result     <= CNT_W'(MAX_REACT);
                        timeout    <= 1'b1;
                        led_go     <= 1'b0;
                        cnt_enable <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    cnt_enable <= 1'b0;
                    led_go     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reaction_ctrl.sv
// Bench for reaction_ctrl paired with a behavioural up-counter; three parameter sets.
module tb_reaction_ctrl;

    logic        clk = 1'b0;
    logic        areset_n = 1'b0;
    logic        start_b [3];
    logic        react_b [3];
    logic        cnt_done [3];
    logic [13:0] cnt_value [3];
    logic        cnt_enable [3];
    logic [13:0] cnt_limit [3];
    logic        led_go [3];
    logic [13:0] result [3];
    logic        result_valid [3];
    logic        too_early [3];
    logic        timeout [3];
    logic [15:0] lfsr_m;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reaction_ctrl u_dut0 (
        .clk(clk), .areset_n(areset_n), .start_btn(start_b[0]), .react_btn(react_b[0]),
        .cnt_done(cnt_done[0]), .cnt_value(cnt_value[0]), .cnt_enable(cnt_enable[0]),
        .cnt_limit(cnt_limit[0]), .led_go(led_go[0]), .result(result[0]),
        .result_valid(result_valid[0]), .too_early(too_early[0]), .timeout(timeout[0]));

    reaction_ctrl #(.MIN_DELAY(5), .RAND_BITS(1), .MAX_REACT(300)) u_dut1 (
        .clk(clk), .areset_n(areset_n), .start_btn(start_b[1]), .react_btn(react_b[1]),
        .cnt_done(cnt_done[1]), .cnt_value(cnt_value[1]), .cnt_enable(cnt_enable[1]),
        .cnt_limit(cnt_limit[1]), .led_go(led_go[1]), .result(result[1]),
        .result_valid(result_valid[1]), .too_early(too_early[1]), .timeout(timeout[1]));

    reaction_ctrl #(.MIN_DELAY(5), .RAND_BITS(1), .MAX_REACT(50)) u_dut2 (
        .clk(clk), .areset_n(areset_n), .start_btn(start_b[2]), .react_btn(react_b[2]),
        .cnt_done(cnt_done[2]), .cnt_value(cnt_value[2]), .cnt_enable(cnt_enable[2]),
        .cnt_limit(cnt_limit[2]), .led_go(led_go[2]), .result(result[2]),
        .result_valid(result_valid[2]), .too_early(too_early[2]), .timeout(timeout[2]));

    // Counter: clears while disabled, counts up and holds at its limit
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!cnt_enable[i]) cnt_value[i] <= '0;
            else if (cnt_value[i] != cnt_limit[i]) cnt_value[i] <= cnt_value[i] + 14'd1;
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) cnt_done[i] = cnt_enable[i] && (cnt_value[i] == cnt_limit[i]);
    end

    // Reference LFSR, x^16+x^14+x^13+x^11, shifted toward the MSB
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) lfsr_m <= 16'hACE1;
        else lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic wait_done(input int i, input int max, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < max; k++) begin
            if (cnt_done[i]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        bit          ok;
        int          exp_lim;
        int          seen;
        for (int i = 0; i < 3; i++) begin
            start_b[i] = 1'b0;
            react_b[i] = 1'b0;
        end

        repeat (3) @(negedge clk);
        check("rst_en", 32'(cnt_enable[0]), 0);
        check("rst_lim", 32'(cnt_limit[0]), 0);
        check("rst_led", 32'(led_go[0]), 0);
        check("rst_flags", {28'd0, result_valid[0], too_early[0], timeout[0], 1'b0}, 0);
        areset_n = 1'b1;
        repeat (3) @(negedge clk);

        // Trial on default parameters: random foreperiod, ARM cycle, GO
        exp_lim = 1000 + int'(lfsr_m[10:0]);
        start_b[0] = 1'b1;
        @(negedge clk);
        check("t1_en", 32'(cnt_enable[0]), 1);
        check("t1_lim", 32'(cnt_limit[0]), 32'(exp_lim));
        check("t1_range", 32'(cnt_limit[0] >= 14'd1000 && cnt_limit[0] <= 14'd3047), 1);
        start_b[0] = 1'b0;
        wait_done(0, 3100, ok);
        check("t1_done_seen", 32'(ok), 1);
        @(negedge clk);
        check("t1_arm_en", 32'(cnt_enable[0]), 0);
        check("t1_arm_led", 32'(led_go[0]), 0);
        @(negedge clk);
        check("t1_go_led", 32'(led_go[0]), 1);
        check("t1_go_en", 32'(cnt_enable[0]), 1);

        // Short foreperiod: react captured at count 237
        exp_lim = 5 + int'(lfsr_m[0]);
        start_b[1] = 1'b1;
        @(negedge clk);
        check("t2_lim", 32'(cnt_limit[1]), 32'(exp_lim));
        start_b[1] = 1'b0;
        wait_done(1, 20, ok);
        check("t2_done_seen", 32'(ok), 1);
        @(negedge clk);
        @(negedge clk);
        check("t2_go_led", 32'(led_go[1]), 1);
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (cnt_value[1] == 14'd237) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("t2_reach_237", 32'(ok), 1);
        react_b[1] = 1'b1;
        @(negedge clk);
        check("t2_result", 32'(result[1]), 237);
        check("t2_valid", 32'(result_valid[1]), 1);
        check("t2_led_off", 32'(led_go[1]), 0);
        check("t2_en_off", 32'(cnt_enable[1]), 0);
        react_b[1] = 1'b0;
        @(negedge clk);
        check("t2_hold", 32'(result[1]), 237);

        // Start and react rise together in SHOW: start wins
        exp_lim = 5 + int'(lfsr_m[0]);
        start_b[1] = 1'b1;
        react_b[1] = 1'b1;
        @(negedge clk);
        check("t3_restart_en", 32'(cnt_enable[1]), 1);
        check("t3_restart_lim", 32'(cnt_limit[1]), 32'(exp_lim));
        check("t3_restart_clr", {17'd0, result[1], result_valid[1]}, 0);
        start_b[1] = 1'b0;
        react_b[1] = 1'b0;
        @(negedge clk);
        react_b[1] = 1'b1;
        @(negedge clk);
        check("t3_early", 32'(too_early[1]), 1);
        check("t3_early_res", 32'(result[1]), 0);
        check("t3_early_en", 32'(cnt_enable[1]), 0);
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (led_go[1]) seen++;
        end
        check("t3_no_go", 32'(seen), 0);
        react_b[1] = 1'b0;
        @(negedge clk);
        exp_lim = 5 + int'(lfsr_m[0]);
        start_b[1] = 1'b1;
        @(negedge clk);
        check("t3_clear_early", 32'(too_early[1]), 0);
        check("t3_rewait_lim", 32'(cnt_limit[1]), 32'(exp_lim));
        start_b[1] = 1'b0;

        // Timeout with no reaction
        start_b[2] = 1'b1;
        @(negedge clk);
        start_b[2] = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (timeout[2]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("t4_timeout", 32'(ok), 1);
        check("t4_result", 32'(result[2]), 50);
        check("t4_valid", 32'(result_valid[2]), 0);
        check("t4_led", 32'(led_go[2]), 0);
        react_b[2] = 1'b1;
        @(negedge clk);
        check("t4_react_ignored", {30'd0, timeout[2], result_valid[2]}, 32'b10);

        // React held through the next whole trial is never an edge
        start_b[2] = 1'b1;
        @(negedge clk);
        check("t5_wait", {30'd0, cnt_enable[2], timeout[2]}, 32'b10);
        start_b[2] = 1'b0;
        seen = 0;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (led_go[2]) seen++;
            if (timeout[2]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("t5_timeout", 32'(ok), 1);
        check("t5_go_seen", 32'(seen > 0), 1);
        check("t5_no_capture", 32'(result_valid[2]), 0);
        check("t5_result", 32'(result[2]), 50);
        check("t5_no_early", 32'(too_early[2]), 0);
        react_b[2] = 1'b0;

        // Asynchronous reset while dut0 is still in GO
        check("t6_pre_go", 32'(led_go[0]), 1);
        #2;
        areset_n = 1'b0;
        #1;
        check("t6_rst_led", 32'(led_go[0]), 0);
        check("t6_rst_en", 32'(cnt_enable[0]), 0);
        check("t6_rst_lim", 32'(cnt_limit[0]), 0);
        @(negedge clk);
        areset_n = 1'b1;
        @(negedge clk);
        exp_lim = 1000 + int'(lfsr_m[10:0]);
        start_b[0] = 1'b1;
        @(negedge clk);
        check("t6_new_en", 32'(cnt_enable[0]), 1);
        check("t6_new_lim", 32'(cnt_limit[0]), 32'(exp_lim));
        start_b[0] = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
